// File: rtl/game_pace_controller.sv
// Frame-rate divider, game FSM and score/high-score keeper for the scroller; all outputs registered, one-cycle latency.
// No backpressure: start/pauseToggle/collision are single-cycle pulses acted on the cycle they are sampled.
module game_pace_controller #(
    parameter int ANIM_HALF   = 208333,
    parameter int SCORE_TICKS = 240,
    parameter int MAX_SCORE   = 30
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       start,
    input  logic       pauseToggle,
    input  logic       collision,
    output logic       animationClOCK,
    output logic [9:0] score,
    output logic [9:0] highScore,
    output logic [1:0] gameState,
    output logic       scoreTick
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int DIV_W = (ANIM_HALF > 1) ? $clog2(ANIM_HALF) : 1;
    localparam int TMR_W = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SCORE_TICKS - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [9:0]       SCORE_MAX = 10'(MAX_SCORE);

    logic [DIV_W-1:0] div_cnt;
    logic [TMR_W-1:0] tmr_cnt;
    logic             div_run;
    logic             div_wrap;
    logic             score_edge;

    always_comb begin
        div_run    = (gameState == ST_IDLE) || (gameState == ST_RUN);
        div_wrap   = div_run && (div_cnt == DIV_LAST);
        // A collision in the same cycle swallows the edge so no late increment sneaks in.
        score_edge = div_wrap && !animationClOCK && (gameState == ST_RUN) && !collision;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            gameState      <= ST_IDLE;
            div_cnt        <= '0;
            tmr_cnt        <= '0;
            score          <= '0;
            highScore      <= '0;
            animationClOCK <= 1'b0;
            scoreTick      <= 1'b0;
        end else begin
            scoreTick <= 1'b0;

            if (gameState == ST_OVER) begin
                div_cnt        <= '0;
                animationClOCK <= 1'b0;
            end else if (div_wrap) begin
                div_cnt        <= '0;
                animationClOCK <= ~animationClOCK;
            end else if (div_run) begin
                div_cnt <= div_cnt + DIV_ONE;
            end

            if (score_edge) begin
                if (tmr_cnt == TMR_LAST) begin
                    tmr_cnt <= '0;
                    if (score < SCORE_MAX) begin
                        score     <= score + 10'd1;
                        scoreTick <= 1'b1;
                    end
                end else begin
                    tmr_cnt <= tmr_cnt + TMR_ONE;
                end
            end

            case (gameState)
                ST_IDLE: begin
                    if (start) begin
                        gameState <= ST_RUN;
                        score     <= '0;
                        tmr_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        gameState <= ST_OVER;
                        if (score > highScore) begin
                            highScore <= score;
                        end
                    end else if (pauseToggle) begin
                        gameState <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pauseToggle) begin
                        gameState <= ST_RUN;
                    end
                end
                default: begin
                    if (start) begin
                        gameState <= ST_RUN;
                        score     <= '0;
                        tmr_cnt   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_pace_controller.sv
// Bench for game_pace_controller: per-cycle compare against an edge-counting model plus directed literal checks.
module tb_game_pace_controller;
    localparam int AH  = 2;
    localparam int ST  = 3;
    localparam int MAX = 4;

    logic       CLOCK;
    logic       RESET;
    logic       start;
    logic       pauseToggle;
    logic       collision;
    logic       animationClOCK;
    logic [9:0] score;
    logic [9:0] highScore;
    logic [1:0] gameState;
    logic       scoreTick;

    int total;
    int passed;

    game_pace_controller #(.ANIM_HALF(AH), .SCORE_TICKS(ST), .MAX_SCORE(MAX)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .start(start),
        .pauseToggle(pauseToggle),
        .collision(collision),
        .animationClOCK(animationClOCK),
        .score(score),
        .highScore(highScore),
        .gameState(gameState),
        .scoreTick(scoreTick)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: divider phase counts cycles mod 2*AH; the score is just rising edges seen this game / ST, capped.
    int m_state;
    int m_phase;
    int m_edges;
    int m_hs;
    bit m_tick;
    bit m_valid;

    function automatic int m_score(input int edges);
        int s;
        s = edges / ST;
        return (s > MAX) ? MAX : s;
    endfunction

    always @(posedge CLOCK) begin
        int  sc;
        bit  rise;
        if (RESET) begin
            m_state = 0; m_phase = 0; m_edges = 0; m_hs = 0; m_tick = 0; m_valid = 1;
        end else if (m_valid) begin
            sc = m_score(m_edges);
            m_tick = 0;
            if (m_state == 0 || m_state == 1) begin
                rise = (m_phase == AH - 1);
                m_phase = (m_phase + 1) % (2 * AH);
                if (m_state == 1 && rise && !collision) begin
                    m_edges++;
                    if (m_edges % ST == 0 && m_edges / ST <= MAX) m_tick = 1;
                end
            end else if (m_state == 3) begin
                m_phase = 0;
            end
            case (m_state)
                0: if (start) begin m_state = 1; m_edges = 0; end
                1: if (collision) begin m_state = 3; if (sc > m_hs) m_hs = sc; end
                   else if (pauseToggle) m_state = 2;
                2: if (pauseToggle) m_state = 1;
                default: if (start) begin m_state = 1; m_edges = 0; m_phase = 0; end
            endcase
        end
    end

    always @(negedge CLOCK) begin
        if (m_valid) begin
            check("cycle_outputs {anim,score,hs,state,tick}",
                  32'({animationClOCK, score, highScore, gameState, scoreTick}),
                  32'({(m_phase >= AH) ? 1'b1 : 1'b0, 10'(m_score(m_edges)), 10'(m_hs), 2'(m_state), m_tick}));
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int toggles;
        int ticks;
        int bad;
        logic prev;
        logic a0;
        logic [9:0] s0;

        total = 0; passed = 0;
        RESET = 1; start = 0; pauseToggle = 0; collision = 0;
        repeat (2) step();
        RESET = 0;
        check("reset_state", 32'(gameState), 0);
        check("reset_score", 32'(score), 0);
        check("reset_hs", 32'(highScore), 0);
        check("reset_anim", 32'(animationClOCK), 0);

        toggles = 0; ticks = 0; prev = animationClOCK;
        repeat (20) begin
            step();
            if (animationClOCK != prev) toggles++;
            prev = animationClOCK;
            ticks += int'(scoreTick);
        end
        check("idle_toggles", toggles, 10);
        check("idle_ticks", ticks, 0);
        check("idle_state", 32'(gameState), 0);

        // First game: saturation.
        start = 1; step(); start = 0; n = 1;
        check("state_after_start", 32'(gameState), 1);
        while (!scoreTick && n < 200) begin step(); n++; end
        check("first_tick_cycle", n, 10);
        check("first_tick_score", 32'(score), 1);
        ticks = 1;
        while (score != 4 && n < 200) begin step(); n++; ticks += int'(scoreTick); end
        check("score4_cycle", n, 46);
        repeat (40) begin step(); ticks += int'(scoreTick); end
        check("sat_ticks", ticks, 4);
        check("sat_score", 32'(score), 4);

        // Second game: pause/resume, then collisions.
        RESET = 1; repeat (2) step(); RESET = 0;
        start = 1; step(); start = 0; n = 1;
        while (!scoreTick && n < 200) begin step(); n++; end
        check("g2_first_tick", n, 10);
        pauseToggle = 1; step(); pauseToggle = 0;
        check("paused_state", 32'(gameState), 2);
        check("paused_anim", 32'(animationClOCK), 1);
        a0 = animationClOCK; s0 = score; bad = 0;
        repeat (30) begin
            step();
            if (animationClOCK != a0 || score != s0 || gameState != 2'd2) bad++;
        end
        check("pause_frozen", bad, 0);
        pauseToggle = 1; step(); pauseToggle = 0; m = 1;
        check("resume_state", 32'(gameState), 1);
        while (!scoreTick && m < 200) begin step(); m++; end
        check("resume_tick_cycle", m, 12);
        check("resume_score", 32'(score), 2);
        while (score != 3 && m < 200) begin step(); m++; end
        check("score3_cycle", m, 24);
        collision = 1; step(); collision = 0;
        check("over_state", 32'(gameState), 3);
        check("over_hs", 32'(highScore), 3);
        step();
        check("over_anim", 32'(animationClOCK), 0);
        check("over_score_kept", 32'(score), 3);

        start = 1; step(); start = 0; n = 1;
        check("restart_state", 32'(gameState), 1);
        check("restart_score", 32'(score), 0);
        while (score != 2 && n < 200) begin step(); n++; end
        check("restart_score2_cycle", n, 23);
        collision = 1; step(); collision = 0;
        check("low_collision_state", 32'(gameState), 3);
        check("hs_kept", 32'(highScore), 3);

        // Collision lands on the same cycle as the 2->3 increment.
        start = 1; step(); start = 0;
        for (int k = 2; k <= 34; k++) step();
        check("pre_coincide_score", 32'(score), 2);
        collision = 1; step(); collision = 0;
        check("coincide_score", 32'(score), 2);
        check("coincide_tick", 32'(scoreTick), 0);
        check("coincide_state", 32'(gameState), 3);
        check("coincide_hs", 32'(highScore), 3);

        // Mid-game reset with a simultaneous start.
        start = 1; step(); start = 0; n = 1;
        while (score != 2 && n < 200) begin step(); n++; end
        check("pre_reset_score", 32'(score), 2);
        RESET = 1; start = 1; step(); RESET = 0; start = 0;
        check("midreset_state", 32'(gameState), 0);
        check("midreset_score", 32'(score), 0);
        check("midreset_hs", 32'(highScore), 0);
        check("midreset_anim", 32'(animationClOCK), 0);
        check("midreset_tick", 32'(scoreTick), 0);
        step();
        check("start_on_reset_ignored", 32'(gameState), 0);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/game_pace_controller.md
Name: game_pace_controller

Overview:
- Upstream pacing stage for the background scroller.
- Divides the system clock into the frame-rate animationClOCK square wave and runs the game state machine (idle/running/paused/game over).
- Produces the 10-bit score that sets scroll speed; tracks high score and emits a one-cycle pulse per score increment for sound/HUD logic.

Parameters:
ANIM_HALF, 208333, system-clock cycles per half period of animationClOCK (50 MHz -> 120 Hz)
SCORE_TICKS, 240, animationClOCK rising edges per score increment while RUNNING (2 s at 120 Hz)
MAX_SCORE, 30, score saturation value; keeps scroll step 100+30*score within 10 bits

Ports:
CLOCK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse, already debounced: begin or restart a game
pauseToggle  input  1  single-cycle pulse: enter or leave PAUSED
collision  input  1  single-cycle pulse from the hit detector: end the game
animationClOCK  output  1  registered square wave, 50% duty, period 2*ANIM_HALF cycles
score  output  10  current score, 0..MAX_SCORE
highScore  output  10  best final score since reset
gameState  output  2  0=IDLE, 1=RUNNING, 2=PAUSED, 3=GAMEOVER
scoreTick  output  1  one-cycle pulse on each score increment

Behaviour:
- Reset, sampled on a CLOCK edge: state IDLE; divider count, score timer, score, highScore, animationClOCK and scoreTick all 0. Reset overrides every other input and applies mid-game.
- All outputs are registered. A state change appears on gameState one cycle after the input pulse is sampled.
- Divider:
  - Counts 0..ANIM_HALF-1 in IDLE and RUNNING.
  - At terminal count it wraps to 0 and toggles animationClOCK.
  - PAUSED: count and animationClOCK level are frozen.
  - GAMEOVER: count is held at 0 and animationClOCK is forced to 0.
- Score timer (0..SCORE_TICKS-1) advances only in RUNNING, on the cycle the divider drives animationClOCK 0->1.
  - At terminal count the timer wraps to 0. If score < MAX_SCORE, score increments and scoreTick is 1 for exactly that cycle.
  - At MAX_SCORE the score holds and scoreTick stays 0.
- Transitions (in priority order within each state):
  - IDLE: start -> RUNNING; score and score timer cleared. Other inputs ignored.
  - RUNNING: collision -> GAMEOVER; else pauseToggle -> PAUSED. start is ignored.
  - PAUSED: pauseToggle -> RUNNING. start and collision are ignored.
  - GAMEOVER: start -> RUNNING; score and score timer cleared, divider restarts from 0.
- Entry to GAMEOVER: highScore <= score if score > highScore. The comparison uses the score value before any increment due in that same cycle.
- Simultaneous events:
  - collision and a score increment in the same RUNNING cycle: the increment and its scoreTick are dropped.
  - collision and pauseToggle together: GAMEOVER wins.
  - start and collision together in RUNNING: GAMEOVER.
- Width rules:
  - score and highScore are unsigned 10-bit.
  - Divider and timer counters are sized to hold ANIM_HALF-1 and SCORE_TICKS-1 respectively.
  - No arithmetic wraps, since score saturates.

Test Plan:
Bench parameters for all scenarios: ANIM_HALF=2, SCORE_TICKS=3, MAX_SCORE=4.
- RESET for 2 cycles then idle 20 cycles -> gameState=0, score=0, highScore=0; animationClOCK toggles every 2 cycles (period 4); scoreTick never asserts.
- start pulse -> gameState=1 next cycle; score=1 with a single-cycle scoreTick on the 3rd animationClOCK rising edge (about 12 cycles later); score reaches 4 after about 48 cycles, then holds at 4 with no further scoreTick.
- pauseToggle at score=1 -> gameState=2; animationClOCK level, divider and score frozen for 30 cycles; second pauseToggle -> gameState=1 and counting resumes from the frozen phase (next increment after the remaining edges only).
- collision at score=3 -> gameState=3, highScore=3, animationClOCK=0. Then start -> score=0, RUNNING; collision at score=2 -> highScore stays 3. Collision coincident with an increment from 2 to 3 -> score stays 2, no scoreTick.
- RESET asserted mid-RUNNING at score=2, highScore=3 -> next cycle gameState=0 and score, highScore, animationClOCK, scoreTick all 0; a start pulse on the reset cycle is ignored.
